// File: rtl/fpu_io_pkg.sv
// Constants and TX state encoding shared by the byte-wide pin interface blocks
// (result transmitter and input collector).
package fpu_io_pkg;

    localparam int WORD_W_DEF = 64;
    localparam int BYTE_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2,
        ST_CSUM = 2'd3
    } tx_state_t;

endpackage

// File: rtl/result_byte_tx_if.sv
// Word-side valid/ready and host-side req/ack signals of result_byte_tx.
// Word side: a word transfers on a clock edge where word_valid && word_ready;
// the producer holds word_in/word_valid stable until that edge.
interface result_byte_tx_if
    import fpu_io_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
);

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ack;
    logic              last_byte;
    logic              busy;
    logic              frame_done;
    tx_state_t         state_dbg;

    modport slave (
        input  word_in,
        input  word_valid,
        input  byte_ack,
        output word_ready,
        output byte_out,
        output byte_valid,
        output last_byte,
        output busy,
        output frame_done,
        output state_dbg
    );

    modport master (
        output word_in,
        output word_valid,
        output byte_ack,
        input  word_ready,
        input  byte_out,
        input  byte_valid,
        input  last_byte,
        input  busy,
        input  frame_done,
        input  state_dbg
    );

endinterface

// File: rtl/result_byte_tx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/result_byte_tx.sv
// Serialises one result word to the host LSB byte first, 4-phase req/ack per byte.
// Build option TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
module result_byte_tx
    import fpu_io_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    result_byte_tx_if.slave bus
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
`ifdef TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NBYTES);
`endif

    tx_state_t         state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [BYTE_W-1:0] byte_q, byte_nxt;
    logic              done_q, done_nxt;
    logic              byte_valid_c;
    logic              last_c;
    logic              ack_s;
`ifdef TX_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_nxt;
`endif

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.byte_ack),
        .q   (ack_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            shreg  <= '0;
            byte_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            byte_q <= byte_nxt;
            done_q <= done_nxt;
        end
    end

`ifdef TX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_nxt;
        end
    end
`endif

    // byte_q changes only on accept and on REL->REQ/CSUM, so it is stable for the whole request.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        shreg_nxt    = shreg;
        byte_nxt     = byte_q;
        done_nxt     = 1'b0;
        byte_valid_c = 1'b0;
        last_c       = 1'b0;
`ifdef TX_CHECKSUM_EN
        csum_nxt     = csum_q;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.word_valid) begin
                    shreg_nxt = bus.word_in;
                    byte_nxt  = bus.word_in[BYTE_W-1:0];
                    idx_nxt   = '0;
                    state_nxt = ST_REQ;
`ifdef TX_CHECKSUM_EN
                    csum_nxt  = '0;
`endif
                end
            end
            ST_REQ: begin
                byte_valid_c = 1'b1;
`ifndef TX_CHECKSUM_EN
                last_c       = (idx == LAST_IDX);
`endif
                if (ack_s) begin
                    state_nxt = ST_REL;
`ifdef TX_CHECKSUM_EN
                    csum_nxt  = csum_q ^ byte_q;
`endif
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    if (idx < LAST_IDX) begin
                        shreg_nxt = shreg >> BYTE_W;
                        byte_nxt  = shreg_nxt[BYTE_W-1:0];
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_REQ;
                    end
`ifdef TX_CHECKSUM_EN
                    else if (idx == LAST_IDX) begin
                        byte_nxt  = csum_q;
                        idx_nxt   = CSUM_IDX;
                        state_nxt = ST_CSUM;
                    end
`endif
                    else begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef TX_CHECKSUM_EN
            ST_CSUM: begin
                // Request phase of the checksum byte; its release reuses REL with idx == NBYTES.
                byte_valid_c = 1'b1;
                last_c       = 1'b1;
                if (ack_s) begin
                    state_nxt = ST_REL;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.word_ready = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = byte_valid_c;
    assign bus.last_byte  = last_c;
    assign bus.frame_done = done_q;
    assign bus.state_dbg  = state;

endmodule
